matmul_job_scheduler: RTL

MATMUL_JOB_SCHEDULER -- requirements
Module: matmul_job_scheduler

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/job_fifo.sv | 49 ++++
 rtl/matmul_job_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul job scheduler: state encoding, default sizes
// and job-descriptor field widths.
package matmul_pkg;

    localparam int unsigned DefN     = 6;
    localparam int unsigned DefAddr  = 12;
    localparam int unsigned IdW      = 4;
    localparam int unsigned NumBases = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StRun,
        StReport
    } state_e;

    function automatic int unsigned job_width(input int unsigned addr);
        return NumBases * addr + IdW;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// Job descriptor FIFO with registered occupancy; push/pop qualification is done by the caller.
module job_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/matmul_job_scheduler.sv
// Queues matmul job descriptors, launches them one at a time on the DMA controller,
// and reports completion or timeout back to the submitter.
module matmul_job_scheduler
    import matmul_pkg::*;
#(
    parameter int unsigned N       = DefN,
    parameter int unsigned ADDR    = DefAddr,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [ADDR-1:0]        job_a_base,
    input  logic [ADDR-1:0]        job_b_base,
    input  logic [ADDR-1:0]        job_c_base,
    input  logic [IdW-1:0]         job_id,
    output logic                   dma_start,
    output logic [ADDR-1:0]        dma_a_base,
    output logic [ADDR-1:0]        dma_b_base,
    output logic [ADDR-1:0]        dma_c_base,
    input  logic                   c_wr,
    output logic                   dma_abort,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [IdW-1:0]         done_id,
    output logic                   done_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned JW = job_width(ADDR);
    localparam int unsigned RW = $clog2(N + 1);
    localparam int unsigned CW = $clog2(TIMEOUT);

    state_e         state_q, state_d;
    logic [RW-1:0]  row_q, row_d, rows_next;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic           err_q, err_d;
    logic [IdW-1:0] tag_q;
    logic [ADDR-1:0] a_q, b_q, c_q;

    logic           push, pop, full;
    logic [JW-1:0]  head;

    assign job_ready = ~full;
    assign push      = job_valid & ~full;

    job_fifo #(
        .WIDTH(JW),
        .DEPTH(DEPTH)
    ) u_job_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata({job_a_base, job_b_base, job_c_base, job_id}),
        .pop  (pop),
        .rdata(head),
        .level(level),
        .full (full)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cyc_d     = cyc_q;
        err_d     = err_q;
        pop       = 1'b0;
        dma_start = 1'b0;
        dma_abort = 1'b0;
        rows_next = row_q + RW'(c_wr);
        unique case (state_q)
            StIdle: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                dma_start = 1'b1;
                row_d     = '0;
                cyc_d     = '0;
                state_d   = StRun;
            end
            StRun: begin
                row_d = rows_next;
                cyc_d = cyc_q + CW'(1);
                // Completion wins over a timeout landing on the same cycle.
                if (rows_next == RW'(N)) begin
                    err_d   = 1'b0;
                    state_d = StReport;
                end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                    dma_abort = 1'b1;
                    err_d     = 1'b1;
                    state_d   = StReport;
                end
            end
            StReport: begin
                if (done_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            if (pop) begin
                a_q   <= head[JW-1 -: ADDR];
                b_q   <= head[JW-ADDR-1 -: ADDR];
                c_q   <= head[JW-2*ADDR-1 -: ADDR];
                tag_q <= head[IdW-1:0];
            end
        end
    end

    assign dma_a_base = a_q;
    assign dma_b_base = b_q;
    assign dma_c_base = c_q;
    assign done_valid = (state_q == StReport);
    assign done_id    = tag_q;
    assign done_err   = err_q;
    assign busy       = (state_q != StIdle);

endmodule
